// File: rtl/timer_apb_sequencer.sv
// timer_apb_sequencer: APB master that loads and starts the 8-bit timer,
// polls its status flag for a set number of periods, then stops it.
module timer_apb_sequencer #(
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_tdr,
    input  logic       cfg_updown,
    input  logic [1:0] cfg_cks,
    input  logic [7:0] cfg_periods,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] event_cnt,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr
);
    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    GAP_LAST = 8'(POLL_GAP - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_TDR, S_WR_LOAD, S_WR_RUN, S_POLL_WAIT,
        S_RD_TSR, S_WR_CLR, S_WR_STOP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          access_q, access_d;
    logic [7:0]    gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          abort_q, abort_d;

    logic [7:0] tdr_q, periods_q;
    logic       updown_q;
    logic [1:0] cks_q;

    logic xfer, xfer_done, abort_ok, abort_hit, bail;
    logic flag_hit, last_period, accept;
    logic [7:0] flag_mask;

    assign accept    = (state_q == S_IDLE) && start;
    assign xfer      = (state_q == S_WR_TDR)  || (state_q == S_WR_LOAD) ||
                       (state_q == S_WR_RUN)  || (state_q == S_RD_TSR)  ||
                       (state_q == S_WR_CLR)  || (state_q == S_WR_STOP);
    assign xfer_done = xfer && access_q && pready;
    assign abort_ok  = (state_q != S_IDLE) && (state_q != S_DONE) &&
                       (state_q != S_WR_STOP);
    // an abort seen at any point of a transfer is held until it completes
    assign abort_hit = abort_ok && (abort || abort_q);
    assign bail      = xfer_done && (pslverr || abort_hit);
    assign flag_mask = {6'b0, updown_q, ~updown_q};
    assign flag_hit  = |(prdata & flag_mask);
    assign last_period = (cnt_q + 8'd1) == periods_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= S_IDLE;
            access_q <= 1'b0;
            gap_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            access_q <= access_d;
            gap_q    <= gap_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q     <= '0;
            periods_q <= '0;
            updown_q  <= 1'b0;
            cks_q     <= '0;
        end else if (accept) begin
            tdr_q     <= cfg_tdr;
            periods_q <= cfg_periods;
            updown_q  <= cfg_updown;
            cks_q     <= cfg_cks;
        end
    end

    always_comb begin
        state_d  = state_q;
        access_d = access_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        if (xfer) access_d = access_q ? !pready : 1'b1;
        if (accept) abort_d = 1'b0;
        else if (abort_ok && abort) abort_d = 1'b1;
        if (state_q == S_POLL_WAIT) gap_d = gap_q + 8'd1;
        if ((state_q == S_POLL_WAIT || state_q == S_RD_TSR) &&
            tmo_q != TMO_MAX)
            tmo_d = tmo_q + 1'b1;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_WR_TDR;
                err_d   = 1'b0;
                cnt_d   = '0;
            end
            S_WR_TDR, S_WR_LOAD, S_WR_RUN: if (bail) begin
                state_d = S_WR_STOP;
                err_d   = 1'b1;
            end else if (xfer_done) begin
                if (state_q == S_WR_TDR) state_d = S_WR_LOAD;
                else if (state_q == S_WR_LOAD) state_d = S_WR_RUN;
                else begin
                    state_d = S_POLL_WAIT;
                    gap_d   = '0;
                    tmo_d   = '0;
                end
            end
            S_POLL_WAIT: if (abort_hit || tmo_q >= TMO_MAX) begin
                state_d = S_WR_STOP;
                err_d   = 1'b1;
            end else if (gap_q >= GAP_LAST) begin
                state_d = S_RD_TSR;
            end
            S_RD_TSR: if (bail) begin
                state_d = S_WR_STOP;
                err_d   = 1'b1;
            end else if (xfer_done) begin
                state_d = flag_hit ? S_WR_CLR : S_POLL_WAIT;
                gap_d   = '0;
            end
            S_WR_CLR: if (xfer_done) begin
                if (!pslverr) cnt_d = cnt_q + 8'd1;
                if (bail || last_period) begin
                    state_d = S_WR_STOP;
                    err_d   = err_q | bail;
                end else begin
                    state_d = S_POLL_WAIT;
                    gap_d   = '0;
                    tmo_d   = '0;
                end
            end
            S_WR_STOP: if (xfer_done) begin
                state_d = S_DONE;
                if (pslverr) err_d = 1'b1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pwrite = 1'b0;
        paddr  = 8'h00;
        pwdata = 8'h00;
        unique case (state_q)
            S_WR_TDR: begin
                pwrite = 1'b1;
                pwdata = tdr_q;
            end
            S_WR_LOAD: begin
                pwrite = 1'b1;
                paddr  = 8'h01;
                pwdata = {2'b10, updown_q, 1'b0, 2'b00, cks_q};
            end
            S_WR_RUN: begin
                pwrite = 1'b1;
                paddr  = 8'h01;
                pwdata = {2'b00, updown_q, 1'b1, 2'b00, cks_q};
            end
            S_RD_TSR: paddr = 8'h02;
            S_WR_CLR: begin
                pwrite = 1'b1;
                paddr  = 8'h02;
            end
            S_WR_STOP: begin
                pwrite = 1'b1;
                paddr  = 8'h01;
                pwdata = {2'b00, updown_q, 1'b0, 2'b00, cks_q};
            end
            default: pwrite = 1'b0;
        endcase
    end

    assign psel      = xfer;
    assign penable   = xfer && access_q;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign err       = err_q;
    assign event_cnt = cnt_q;
endmodule

// File: tb/tb_timer_apb_sequencer.sv
// tb_timer_apb_sequencer: APB slave model with a transaction scoreboard
// and directed sequences for the timer sequencer.
module tb_timer_apb_sequencer;
    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_tdr = '0;
    logic       cfg_updown = 1'b0;
    logic [1:0] cfg_cks = '0;
    logic [7:0] cfg_periods = '0;
    logic       busy, done, err;
    logic [7:0] event_cnt;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata = '0;
    logic       pready = 1'b0;
    logic       pslverr = 1'b0;

    always #5 pclk = ~pclk;

    timer_apb_sequencer #(.POLL_GAP(4), .TIMEOUT(20)) dut (
        .pclk(pclk), .presetn(presetn), .start(start), .abort(abort),
        .cfg_tdr(cfg_tdr), .cfg_updown(cfg_updown), .cfg_cks(cfg_cks),
        .cfg_periods(cfg_periods), .busy(busy), .done(done), .err(err),
        .event_cnt(event_cnt), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    int wr_waits = 0;
    int rd_waits = 0;
    int flag_after = 0;
    int err_idx = -1;
    int xfer_idx = 0;
    int rd_cnt = 0;
    int wait_cnt = 0;
    bit noise = 1'b0;
    bit tb_ud = 1'b0;
    logic       prev_psel = 1'b0;
    logic       snap_wr = 1'b0;
    logic [7:0] snap_addr = '0;
    logic [7:0] snap_data = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // slave response and scoreboard monitor
    always @(negedge pclk) begin
        txn_t e;
        if (presetn && psel && !penable) begin
            snap_wr   = pwrite;
            snap_addr = paddr;
            snap_data = pwdata;
            pready    = 1'b0;
            pslverr   = 1'b0;
            wait_cnt  = 0;
        end else if (presetn && psel && penable) begin
            chk("bus_stable", {prev_psel, pwrite, paddr, pwdata},
                {1'b1, snap_wr, snap_addr, snap_data});
            if (wait_cnt < (pwrite ? wr_waits : rd_waits)) begin
                pready  = 1'b0;
                pslverr = 1'b0;
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                pready   = 1'b1;
                pslverr  = (xfer_idx == err_idx);
                prdata   = noise ? (tb_ud ? 8'hF1 : 8'hF2) : 8'h00;
                if (!pwrite && paddr == 8'h02) begin
                    if (rd_cnt >= flag_after) prdata[tb_ud ? 1 : 0] = 1'b1;
                    rd_cnt++;
                end
                if (pwrite && paddr == 8'h02) rd_cnt = 0;
                xfer_idx++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL txn_extra: got w%0d %0h<-%0h none expected",
                             pwrite, paddr, pwdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn", {pwrite, paddr, pwrite ? pwdata : 8'h00},
                        {e.wr, e.addr, e.data});
                end
            end
        end else begin
            pready   = 1'b0;
            pslverr  = 1'b0;
            wait_cnt = 0;
        end
        prev_psel = psel;
    end

    function automatic logic [7:0] tcr(bit ld, bit ud, bit run,
                                       logic [1:0] cks);
        return {ld, 1'b0, ud, run, 2'b00, cks};
    endfunction

    task automatic push(bit wr, logic [7:0] a, logic [7:0] d);
        txn_t t;
        t.wr = wr;
        t.addr = a;
        t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic push_head(logic [7:0] tdr, bit ud, logic [1:0] cks);
        push(1, 8'h00, tdr);
        push(1, 8'h01, tcr(1, ud, 0, cks));
        push(1, 8'h01, tcr(0, ud, 1, cks));
    endtask

    task automatic push_reads(int n);
        for (int i = 0; i < n; i++) push(0, 8'h02, 8'h00);
    endtask

    task automatic push_period(int nreads);
        push_reads(nreads);
        push(1, 8'h02, 8'h00);
    endtask

    task automatic push_stop(bit ud, logic [1:0] cks);
        push(1, 8'h01, tcr(0, ud, 0, cks));
    endtask

    task automatic do_start(logic [7:0] tdr, bit ud, logic [1:0] cks,
                            logic [7:0] per);
        @(negedge pclk);
        cfg_tdr = tdr;
        cfg_updown = ud;
        cfg_cks = cks;
        cfg_periods = per;
        tb_ud = ud;
        rd_cnt = 0;
        xfer_idx = 0;
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        cfg_tdr = ~tdr;
        cfg_updown = ~ud;
        cfg_cks = ~cks;
        cfg_periods = per + 8'd5;
        chk("start_setup", {busy, psel, penable, paddr, err, event_cnt},
            {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00});
    endtask

    task automatic wait_done(string name, logic [7:0] ecnt, bit eerr);
        int k = 0;
        while (done !== 1'b1 && k < 3000) begin
            @(negedge pclk);
            k++;
        end
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_cnt"}, event_cnt, ecnt);
        chk({name, "_err"}, err, eerr);
        chk({name, "_left"}, exp_q.size(), 0);
        @(negedge pclk);
        chk({name, "_end"}, {done, busy, err}, {1'b0, 1'b0, eerr});
    endtask

    initial begin
        int k;
        repeat (3) @(negedge pclk);
        chk("reset_out", {psel, penable, pwrite, paddr, pwdata,
                          busy, done, err, event_cnt}, 0);
        presetn = 1'b1;
        repeat (2) @(negedge pclk);
        chk("idle_out", {psel, busy, done, err}, 0);

        // count down, one period, flag on second read
        flag_after = 1;
        push_head(8'h05, 1, 2'd0);
        push_period(2);
        push_stop(1, 2'd0);
        do_start(8'h05, 1, 2'd0, 8'd1);
        wait_done("down", 8'd1, 0);

        // count up, three periods, opposite flag always set
        noise = 1'b1;
        push_head(8'hFD, 0, 2'd2);
        for (int i = 0; i < 3; i++) push_period(2);
        push_stop(0, 2'd2);
        do_start(8'hFD, 0, 2'd2, 8'd3);
        wait_done("up3", 8'd3, 0);
        noise = 1'b0;

        // wait states on every transfer
        wr_waits = 3;
        rd_waits = 3;
        flag_after = 0;
        push_head(8'h5A, 0, 2'd1);
        push_period(1);
        push_period(1);
        push_stop(0, 2'd1);
        do_start(8'h5A, 0, 2'd1, 8'd2);
        wait_done("waits", 8'd2, 0);
        wr_waits = 0;
        rd_waits = 0;

        // slave error on WR_LOAD
        err_idx = 1;
        push(1, 8'h00, 8'h11);
        push(1, 8'h01, tcr(1, 1, 0, 2'd0));
        push_stop(1, 2'd0);
        do_start(8'h11, 1, 2'd0, 8'd1);
        wait_done("slverr", 8'd0, 1);
        err_idx = -1;

        // abort while the TSR read is stalled
        rd_waits = 6;
        flag_after = 100;
        push_head(8'h20, 0, 2'd3);
        push_reads(1);
        push_stop(0, 2'd3);
        do_start(8'h20, 0, 2'd3, 8'd1);
        k = 0;
        while (!(psel && penable && !pwrite) && k < 200) begin
            @(negedge pclk);
            k++;
        end
        chk("abort_trig", k < 200, 1'b1);
        abort = 1'b1;
        wait_done("abort", 8'd0, 1);
        abort = 1'b0;
        rd_waits = 0;

        // timeout with the flag never set
        push_head(8'h07, 1, 2'd0);
        push_reads(3);
        push_stop(1, 2'd0);
        do_start(8'h07, 1, 2'd0, 8'd1);
        wait_done("timeout", 8'd0, 1);

        // reset pulsed during WR_RUN
        wr_waits = 2;
        push_head(8'h33, 1, 2'd1);
        do_start(8'h33, 1, 2'd1, 8'd1);
        k = 0;
        while (!(psel && paddr == 8'h01 && pwdata == tcr(0, 1, 1, 2'd1))
               && k < 200) begin
            @(negedge pclk);
            k++;
        end
        chk("run_trig", k < 200, 1'b1);
        #2 presetn = 1'b0;
        #1;
        chk("reset_async", {psel, penable, pwrite, paddr, pwdata,
                            busy, done, err, event_cnt}, 0);
        exp_q.delete();
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        wr_waits = 0;
        flag_after = 0;
        push_head(8'h44, 1, 2'd1);
        push_period(1);
        push_stop(1, 2'd1);
        do_start(8'h44, 1, 2'd1, 8'd1);
        wait_done("after_rst", 8'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end expected end of test");
        $fatal(1, "watchdog");
    end
endmodule
